// File: rtl/ed25519_pkg.sv
// Shared ed25519 definitions: coordinate width, field constants, the
// extended-coordinate point type and the scalar-multiplication FSM states.
package ed25519_pkg;

    localparam int W = 255;

    // z = 1 convention of the point unit
    localparam logic [W-1:0] ONE  = 255'd1;

    localparam logic [W-1:0] ID_X = '0;
    localparam logic [W-1:0] ID_Y = ONE;
    localparam logic [W-1:0] ID_Z = ONE;
    localparam logic [W-1:0] ID_T = '0;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic [W-1:0] t;
    } point_t;

    localparam point_t IDENTITY = {ID_X, ID_Y, ID_Z, ID_T};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_REQ  = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_DBL_REQ   = 3'd3,
        ST_DBL_WAIT  = 3'd4,
        ST_ADD_REQ   = 3'd5,
        ST_ADD_WAIT  = 3'd6
    } state_t;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Constant-time double-and-always-add controller: Q = k*P, driving the
// external point unit through its start/doubling/initial/finished handshake.
module scalar_mult_ctrl
    import ed25519_pkg::*;
#(
    parameter int NBITS = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_k,
    input  logic [W-1:0]     i_x,
    input  logic [W-1:0]     i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic [W-1:0]     o_x,
    output logic [W-1:0]     o_y,
    output logic [W-1:0]     o_z,
    output logic [W-1:0]     o_t,
    output logic             o_pa_start,
    output logic             o_pa_doubling,
    output logic             o_pa_initial,
    output logic [W-1:0]     o_pa_x1,
    output logic [W-1:0]     o_pa_y1,
    output logic [W-1:0]     o_pa_z1,
    output logic [W-1:0]     o_pa_t1,
    output logic [W-1:0]     o_pa_x2,
    output logic [W-1:0]     o_pa_y2,
    output logic [W-1:0]     o_pa_z2,
    output logic [W-1:0]     o_pa_t2,
    input  logic [W-1:0]     i_pa_x3,
    input  logic [W-1:0]     i_pa_y3,
    input  logic [W-1:0]     i_pa_z3,
    input  logic [W-1:0]     i_pa_t3,
    input  logic             i_pa_finished
);

    localparam int             IW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IW-1:0]  IDX_TOP = IW'(NBITS - 1);

    state_t           state_q, state_d;
    logic [NBITS-1:0] k_q, k_d;
    logic [W-1:0]     bx_q, bx_d, by_q, by_d;
    logic [IW-1:0]    idx_q, idx_d;
    point_t           p_q, p_d;
    point_t           q_q, q_d;
    point_t           res_q, res_d;
    point_t           op1_q, op1_d;
    point_t           op2_q, op2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic             dbl_q, dbl_d;
    logic             init_q, init_d;

    point_t           pa_res;
    point_t           q_after_add;

    assign pa_res = {i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3};

    // The ADD always runs; the scalar bit only decides whether its result is kept.
    assign q_after_add = k_q[idx_q] ? pa_res : q_q;

    always_comb begin
        // NOTE: every _d starts from its hold value so no path through the case infers a latch.
        state_d = state_q;
        k_d     = k_q;
        bx_d    = bx_q;
        by_d    = by_q;
        idx_d   = idx_q;
        p_d     = p_q;
        q_d     = q_q;
        res_d   = res_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        busy_d  = busy_q;
        dbl_d   = dbl_q;
        init_d  = init_q;
        start_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    k_d     = i_k;
                    bx_d    = i_x;
                    by_d    = i_y;
                    q_d     = IDENTITY;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = ST_INIT_REQ;
                end
            end
            ST_INIT_REQ: begin
                start_d = 1'b1;
                init_d  = 1'b1;
                dbl_d   = 1'b0;
                op1_d   = {bx_q, by_q, {W{1'b0}}, {W{1'b0}}};
                op2_d   = '0;
                state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (i_pa_finished) begin
                    p_d     = pa_res;
                    state_d = ST_DBL_REQ;
                end
            end
            ST_DBL_REQ: begin
                start_d = 1'b1;
                init_d  = 1'b0;
                dbl_d   = 1'b1;
                op1_d   = q_q;
                op2_d   = '0;
                state_d = ST_DBL_WAIT;
            end
            ST_DBL_WAIT: begin
                if (i_pa_finished) begin
                    q_d     = pa_res;
                    state_d = ST_ADD_REQ;
                end
            end
            ST_ADD_REQ: begin
                start_d = 1'b1;
                init_d  = 1'b0;
                dbl_d   = 1'b0;
                op1_d   = q_q;
                op2_d   = p_q;
                state_d = ST_ADD_WAIT;
            end
            ST_ADD_WAIT: begin
                if (i_pa_finished) begin
                    q_d = q_after_add;
                    if (idx_q == '0) begin
                        res_d   = q_after_add;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = ST_DBL_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the wide datapath registers are cleared too, so an aborted run leaves nothing on the outputs.
            state_q <= ST_IDLE;
            k_q     <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            idx_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            res_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            dbl_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            q_q     <= q_d;
            res_q   <= res_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            dbl_q   <= dbl_d;
            init_q  <= init_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_x           = res_q.x;
    assign o_y           = res_q.y;
    assign o_z           = res_q.z;
    assign o_t           = res_q.t;
    assign o_pa_start    = start_q;
    assign o_pa_doubling = dbl_q;
    assign o_pa_initial  = init_q;
    assign o_pa_x1       = op1_q.x;
    assign o_pa_y1       = op1_q.y;
    assign o_pa_z1       = op1_q.z;
    assign o_pa_t1       = op1_q.t;
    assign o_pa_x2       = op2_q.x;
    assign o_pa_y2       = op2_q.y;
    assign o_pa_z2       = op2_q.z;
    assign o_pa_t2       = op2_q.t;

endmodule
